// File: rtl/memory_sequencer_pkg.sv
// memory_sequencer_pkg: shared state, op and strobe encodings for the burst memory sequencer
package memory_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam logic OP_READ    = 1'b0;
  localparam logic OP_WRITE   = 1'b1;
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;
endpackage

// File: rtl/memory_sequencer_burst_counter.sv
// burst_counter: wrapping address register plus remaining-beat down-counter with last flag
module burst_counter #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] addr,
  output logic          last
);
  logic [AW:0] remaining;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= len;
    end else if (step) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end
  assign last = remaining == (AW+1)'(1);
endmodule

// File: rtl/memory_sequencer.sv
// memory_sequencer: burst master streaming host beats into or out of a single-port synchronous memory
module memory_sequencer
  import memory_sequencer_pkg::*;
#(
  parameter int BIT_DEPTH     = 8,
  parameter int ADDRESS_LINES = 7
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic                     Op,
  input  logic [ADDRESS_LINES-1:0] Base,
  input  logic [ADDRESS_LINES:0]   Len,
  input  logic [BIT_DEPTH-1:0]     WData,
  input  logic                     WValid,
  output logic                     WReady,
  output logic [BIT_DEPTH-1:0]     RData,
  output logic                     RValid,
  output logic                     Busy,
  output logic                     Done,
  output logic                     CS,
  output logic                     RD,
  output logic                     WR,
  output logic [ADDRESS_LINES-1:0] Add,
  output logic [BIT_DEPTH-1:0]     Din,
  input  logic [BIT_DEPTH-1:0]     Dout
);
  state_t                   state, state_next;
  logic [ADDRESS_LINES-1:0] addr;
  logic                     last, load, wr_fire, rd_fire, rvalid;
  assign load    = state == IDLE && Start && Len != '0;
  assign wr_fire = state == WRITE && WValid;
  assign rd_fire = state == READ;
  burst_counter #(.AW(ADDRESS_LINES)) u_counter (
    .clk  (Clk),
    .rst  (Rst),
    .load (load),
    .step (wr_fire || rd_fire),
    .base (Base),
    .len  (Len),
    .addr (addr),
    .last (last)
  );
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      rvalid <= 1'b0;
    end else begin
      state  <= state_next;
      rvalid <= rd_fire;
    end
  end
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = !Start ? IDLE : Len == '0 ? DONE : Op == OP_WRITE ? WRITE : READ;
      WRITE:   state_next = wr_fire && last ? DONE : WRITE;
      READ:    state_next = last ? DRAIN : READ;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  assign CS     = wr_fire || rd_fire ? STROBE_ON : STROBE_OFF;
  assign WR     = wr_fire ? STROBE_ON : STROBE_OFF;
  assign RD     = rd_fire ? STROBE_ON : STROBE_OFF;
  assign Add    = wr_fire || rd_fire ? addr : '0;
  assign Din    = wr_fire ? WData : '0;
  assign WReady = state == WRITE;
  assign Busy   = state != IDLE;
  assign Done   = state == DONE;
  assign RValid = rvalid;
  assign RData  = Dout;
endmodule
